stp_rx_ctrl: RTL and testbench
==============================

Name: stp_rx_ctrl

Overview:
- Receive control unit that sequences a serial-to-parallel shift register on an idle-high serial line.
- Detects the start bit, times mid-bit sampling, pulses the shift enable once per data bit, checks the stop bit and commands the parallel output buffer load.
- Tracks ready, framing and overrun status for the downstream reader.
- Sits between the serial input pin (already synchronized upstream) and the StP register / output buffer.

Parameters:
- NUM_BITS, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 10, clk cycles per bit period (even, >=4).

Ports:
- clk, input, 1, system clock, rising edge.
- n_rst, input, 1, asynchronous active-low reset.
- serial_in, input, 1, synchronized serial line; idles high.
- data_read, input, 1, reader acknowledges the buffer; clears data_ready and overrun_error.
- shift_strobe, output, 1, one-cycle shift enable to the StP register at each data-bit mid-point.
- load_buffer, output, 1, one-cycle pulse: copy StP contents to the output buffer.
- busy, output, 1, high whenever state != IDLE.
- data_ready, output, 1, sticky; a valid frame is in the buffer.
- framing_error, output, 1, sticky; the last frame had a low stop bit.
- overrun_error, output, 1, sticky; the buffer was reloaded while data_ready was set and unread.

Behaviour:
- Reset: async on n_rst low.
  - State = IDLE.
  - All outputs 0.
  - Timer and bit counter = 0.
  - Previous-line register = 1.
  - Reset mid-frame abandons the frame and issues no load.
- Start detect: in IDLE, a start is detected at the clk edge E where prev=1 and serial_in=0.
  - State goes to START_CHK and framing_error clears.
  - A line held low from reset does not start a frame until it returns high.
- START_CHK: count CLKS_PER_BIT/2 cycles, then sample at edge E+CLKS_PER_BIT/2.
  - Sample 0: go to SHIFT with timer = 0.
  - Sample 1: glitch; return to IDLE with no other effect.
- SHIFT: timer counts 1..CLKS_PER_BIT.
  - At terminal count, shift_strobe is high for exactly one cycle, the bit counter increments and the timer wraps to 0.
  - The k-th strobe occurs at E+CLKS_PER_BIT/2+k*CLKS_PER_BIT, for k=1..NUM_BITS.
  - After strobe NUM_BITS, go to STOP_CHK.
- STOP_CHK: wait CLKS_PER_BIT cycles, then sample serial_in.
  - Sample 1: go to LOAD.
  - Sample 0: set framing_error, no load, go to WAIT_IDLE.
- LOAD: one cycle.
  - load_buffer = 1.
  - On the next edge data_ready is set.
  - If data_ready was already 1 and data_read = 0 in this cycle, overrun_error is also set.
  - Then go to IDLE.
- WAIT_IDLE: remain until serial_in = 1, then go to IDLE.
- data_read:
  - In any cycle other than a LOAD cycle, data_read clears data_ready and overrun_error on the next edge.
  - If data_read and load_buffer coincide, data_ready stays 1 and no overrun is flagged.
- A new start edge arriving in IDLE immediately after LOAD is accepted, giving back-to-back frames.
- Counter widths are sized by $clog2 of their parameter; no wrap occurs within a legal frame.

Optional Feature:
- Macro: STP_RX_PARITY_EN.
- When defined:
  - A PARITY_CHK state is inserted between SHIFT and STOP_CHK, sampled CLKS_PER_BIT cycles after the last data strobe. It issues no shift_strobe.
  - Even parity is accumulated over the serial_in values sampled at each shift_strobe plus the parity bit.
  - A mismatch sets an added output port parity_error (1 bit, sticky). It is cleared at the next start detect.
  - The load still occurs if the stop bit is good.
- When undefined: no parity_error port and no parity state; frame timing is exactly as in Behaviour.

Test Plan:
- Defaults; idle high 20 cycles, then frame start/0xA5 LSB-first/stop=1 with edge at E -> shift_strobe at E+15, E+25 … E+85 (8 pulses); load_buffer at E+96; data_ready=1 from E+97; framing_error=0.
- Line low for 3 cycles at E, then high -> START_CHK sample at E+5 sees 1; back to IDLE with no strobes; busy low from E+6.
- Frame with stop bit = 0 -> framing_error=1, no load_buffer, busy stays high until the line goes high; the next good frame clears framing_error at its start edge.
- Two frames back-to-back without data_read -> second load sets overrun_error=1, data_ready stays 1; then data_read=1 for one cycle -> both clear.
- n_rst pulsed low at E+40 mid-frame with the line still low -> all outputs 0 immediately; no strobes or load until the line goes high and a new falling edge occurs.
- With STP_RX_PARITY_EN: data 0x07 with parity bit 0 -> parity_error=1 and load still occurs; with parity bit 1 -> parity_error=0.

Source files
------------

// File: rtl/stp_rx_if.sv
// Handshake bundle between the serial-to-parallel receive controller and its
// neighbours. The serial line, the reader acknowledge and all status and strobe
// outputs travel here; clk and n_rst stay plain ports on the controller.
// The optional parity_error signal exists only when STP_RX_PARITY_EN is defined.
interface stp_rx_if;
   logic serial_in;
   logic data_read;
   logic shift_strobe;
   logic load_buffer;
   logic busy;
   logic data_ready;
   logic framing_error;
   logic overrun_error;
`ifdef STP_RX_PARITY_EN
   logic parity_error;

   modport slave (
      input  serial_in, data_read,
      output shift_strobe, load_buffer, busy, data_ready,
             framing_error, overrun_error, parity_error
   );

   modport master (
      output serial_in, data_read,
      input  shift_strobe, load_buffer, busy, data_ready,
             framing_error, overrun_error, parity_error
   );
`else
   modport slave (
      input  serial_in, data_read,
      output shift_strobe, load_buffer, busy, data_ready,
             framing_error, overrun_error
   );

   modport master (
      output serial_in, data_read,
      input  shift_strobe, load_buffer, busy, data_ready,
             framing_error, overrun_error
   );
`endif
endinterface

// File: rtl/stp_rx_ctrl.sv
// Receive sequencer for an idle-high serial line feeding a StP shift register.
// Finds the start edge, times mid-bit sampling, strobes the shift register once
// per data bit, checks the stop bit and commands the output-buffer load.
// Optional even-parity bit between data and stop: define STP_RX_PARITY_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | line idle, waiting for a high-to-low transition
// START_CHK  | half a bit after the edge, confirm the start bit is still low
// SHIFT      | one strobe per bit period, NUM_BITS strobes in total
// PARITY_CHK | sample the parity bit one bit period after the last strobe
// STOP_CHK   | sample the stop bit
// LOAD       | single cycle: copy StP contents to the output buffer
// WAIT_IDLE  | bad stop bit; hold until the line returns high
module stp_rx_ctrl #(
   parameter int NUM_BITS     = 8,
   parameter int CLKS_PER_BIT = 10
) (
   input  logic      clk,
   input  logic      n_rst,
   stp_rx_if.slave   bus
);

   localparam int TMR_W = $clog2(CLKS_PER_BIT + 1);
   localparam int CNT_W = $clog2(NUM_BITS + 1);

   localparam logic [TMR_W-1:0] T_HALF_LAST = TMR_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TMR_W-1:0] T_BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);
   localparam logic [TMR_W-1:0] T_BIT_FULL  = TMR_W'(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(NUM_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START_CHK,
      SHIFT,
`ifdef STP_RX_PARITY_EN
      PARITY_CHK,
`endif
      STOP_CHK,
      LOAD,
      WAIT_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             strobe_q, strobe_d;
   logic             prev_q;
   logic             armed_q;
   logic             ready_q, ready_d;
   logic             ferr_q, ferr_d;
   logic             ovr_q, ovr_d;
`ifdef STP_RX_PARITY_EN
   logic             par_acc_q, par_acc_d;
   logic             perr_q, perr_d;
`endif

   logic start_det;

   // A start needs a real high-to-low transition; armed_q blocks a line that
   // has been low ever since reset from looking like one.
   assign start_det = armed_q && prev_q && !bus.serial_in;

   // Line history and all sequencer state registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         strobe_q  <= 1'b0;
         prev_q    <= 1'b1;
         armed_q   <= 1'b0;
         ready_q   <= 1'b0;
         ferr_q    <= 1'b0;
         ovr_q     <= 1'b0;
`ifdef STP_RX_PARITY_EN
         par_acc_q <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         strobe_q  <= strobe_d;
         prev_q    <= bus.serial_in;
         armed_q   <= armed_q | bus.serial_in;
         ready_q   <= ready_d;
         ferr_q    <= ferr_d;
         ovr_q     <= ovr_d;
`ifdef STP_RX_PARITY_EN
         par_acc_q <= par_acc_d;
         perr_q    <= perr_d;
`endif
      end
   end

   // Next-state, bit timing and sticky status update.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + TMR_W'(1);
      bit_cnt_d = bit_cnt_q;
      strobe_d  = 1'b0;
      ready_d   = ready_q;
      ferr_d    = ferr_q;
      ovr_d     = ovr_q;
`ifdef STP_RX_PARITY_EN
      par_acc_d = par_acc_q;
      perr_d    = perr_q;
      // Fold in the same line value the StP register captures on this edge.
      if (strobe_q) begin
         par_acc_d = par_acc_q ^ bus.serial_in;
      end
`endif

      // A read in the load cycle is ignored so the fresh frame stays flagged.
      if (bus.data_read && state_q != LOAD) begin
         ready_d = 1'b0;
         ovr_d   = 1'b0;
      end

      case (state_q)
         IDLE: begin
            timer_d   = '0;
            bit_cnt_d = '0;
            if (start_det) begin
               state_d = START_CHK;
               ferr_d  = 1'b0;
`ifdef STP_RX_PARITY_EN
               perr_d    = 1'b0;
               par_acc_d = 1'b0;
`endif
            end
         end
         START_CHK: begin
            if (timer_q == T_HALF_LAST) begin
               timer_d = '0;
               state_d = bus.serial_in ? IDLE : SHIFT;
            end
         end
         SHIFT: begin
            if (timer_q == T_BIT_LAST) begin
               timer_d   = '0;
               strobe_d  = 1'b1;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_LAST) begin
`ifdef STP_RX_PARITY_EN
                  state_d = PARITY_CHK;
`else
                  state_d = STOP_CHK;
`endif
               end
            end
         end
`ifdef STP_RX_PARITY_EN
         PARITY_CHK: begin
            if (timer_q == T_BIT_LAST) begin
               timer_d = '0;
               state_d = STOP_CHK;
               if (par_acc_q ^ bus.serial_in) begin
                  perr_d = 1'b1;
               end
            end
         end
`endif
         STOP_CHK: begin
            // Sampled on the same edge phase at which the StP register
            // captures data bits, one bit period after the previous sample.
            if (timer_q == T_BIT_FULL) begin
               timer_d = '0;
               if (bus.serial_in) begin
                  state_d = LOAD;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_IDLE;
               end
            end
         end
         LOAD: begin
            timer_d = '0;
            state_d = IDLE;
            ready_d = 1'b1;
            if (ready_q && !bus.data_read) begin
               ovr_d = 1'b1;
            end
         end
         WAIT_IDLE: begin
            timer_d = '0;
            if (bus.serial_in) begin
               state_d = IDLE;
            end
         end
         default: begin
            timer_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign bus.shift_strobe  = strobe_q;
   assign bus.load_buffer   = (state_q == LOAD);
   assign bus.busy          = (state_q != IDLE);
   assign bus.data_ready    = ready_q;
   assign bus.framing_error = ferr_q;
   assign bus.overrun_error = ovr_q;
`ifdef STP_RX_PARITY_EN
   assign bus.parity_error  = perr_q;
`endif

endmodule

// File: tb/tb_stp_rx_ctrl.sv
// Directed bench for stp_rx_ctrl with default parameters (8 bits, 10 clk/bit).
// Build with STP_RX_PARITY_EN defined to exercise the parity variant.
module tb_stp_rx_ctrl;

   localparam int NB  = 8;
   localparam int CPB = 10;
`ifdef STP_RX_PARITY_EN
   localparam int LOAD_T = 106;
   localparam int PAR_K  = NB + 1;
   localparam int STOP_K = NB + 2;
`else
   localparam int LOAD_T = 96;
   localparam int PAR_K  = -1;
   localparam int STOP_K = NB + 1;
`endif
   localparam int T_END = LOAD_T + 8;

   logic clk   = 1'b0;
   logic n_rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   stp_rx_if bus ();

   stp_rx_ctrl #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [NB-1:0] data;
      logic          stop;
      logic          rd_before;
      logic          rd_at_load;
      logic          exp_load;
      logic          exp_fe;
      logic          exp_dr;
      logic          exp_ovr;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic line_at(input int k, input logic [NB-1:0] d,
                                    input logic p, input logic s);
      if (k == 0)                 return 1'b0;
      else if (k <= NB)           return d[k-1];
      else if (k == PAR_K)        return p;
      else if (k == STOP_K)       return s;
      else                        return 1'b1;
   endfunction

   function automatic logic [31:0] all_out();
      logic [31:0] v;
      v = {26'd0, bus.shift_strobe, bus.load_buffer, bus.busy,
           bus.data_ready, bus.framing_error, bus.overrun_error};
`ifdef STP_RX_PARITY_EN
      v[6] = bus.parity_error;
`endif
      return v;
   endfunction

   // One frame: start edge lands on posedge E; t counts negedges after E+t.
   task automatic run_frame(input logic [NB-1:0] data, input logic par, input logic stop,
                            input logic rd_before, input logic rd_at_load,
                            input logic exp_load, input logic exp_fe, input logic exp_dr,
                            input logic exp_ovr, input logic exp_pe);
      int strobes  = 0;
      int bad_strb = 0;
      int loads    = 0;
      int bad_load = 0;
      logic [NB-1:0] cap = '0;
      logic strb_exp;
      if (rd_before) begin
         @(negedge clk); bus.data_read = 1'b1;
         @(negedge clk); bus.data_read = 1'b0;
         chk("read_clears_ready", {31'd0, bus.data_ready}, 32'd0);
         chk("read_clears_ovr", {31'd0, bus.overrun_error}, 32'd0);
      end
      @(negedge clk);
      bus.serial_in = 1'b0;
      for (int t = 0; t <= T_END; t++) begin
         @(negedge clk);
         if (t == 0) begin
            chk("start_busy", {31'd0, bus.busy}, 32'd1);
            chk("start_clears_fe", {31'd0, bus.framing_error}, 32'd0);
`ifdef STP_RX_PARITY_EN
            chk("start_clears_pe", {31'd0, bus.parity_error}, 32'd0);
`endif
         end
         strb_exp = (t >= 15) && ((t - 15) % CPB == 0) && (t <= 15 + CPB * (NB - 1));
         if (bus.shift_strobe) strobes++;
         if (bus.shift_strobe !== strb_exp) bad_strb++;
         if (bus.load_buffer) begin
            loads++;
            if (t != LOAD_T) bad_load++;
         end
         if (t == LOAD_T + 1) chk("ready_after_load", {31'd0, bus.data_ready}, {31'd0, exp_dr});
         if (!stop && t == LOAD_T + 2) chk("wait_idle_busy", {31'd0, bus.busy}, 32'd1);
         bus.serial_in = line_at((t + 1) / CPB, data, par, stop);
         bus.data_read = rd_at_load && (t == LOAD_T);
         if (bus.shift_strobe) cap = {bus.serial_in, cap[NB-1:1]};
      end
      chk("strobe_timing", bad_strb, 0);
      chk("strobe_count", strobes, NB);
      chk("load_count", loads, {31'd0, exp_load});
      chk("load_timing", bad_load, 0);
      chk("captured_data", {24'd0, cap}, {24'd0, data});
      chk("framing_error", {31'd0, bus.framing_error}, {31'd0, exp_fe});
      chk("overrun_error", {31'd0, bus.overrun_error}, {31'd0, exp_ovr});
      chk("data_ready_end", {31'd0, bus.data_ready}, {31'd0, exp_dr});
      chk("busy_end", {31'd0, bus.busy}, 32'd0);
`ifdef STP_RX_PARITY_EN
      chk("parity_error", {31'd0, bus.parity_error}, {31'd0, exp_pe});
`else
      if (exp_pe) $display("note: parity expectation ignored in this build");
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int   cnt;
      vecs[0] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

      // Reset with the line held low, then release and keep it low.
      bus.serial_in = 1'b0;
      bus.data_read = 1'b0;
      n_rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", all_out(), 32'd0);
      n_rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.busy) cnt++;
      end
      chk("low_from_reset_no_start", cnt, 0);
      bus.serial_in = 1'b1;
      repeat (5) @(negedge clk);

      // Start glitch: low for three cycles only.
      cnt = 0;
      @(negedge clk);
      bus.serial_in = 1'b0;
      for (int t = 0; t <= 30; t++) begin
         @(negedge clk);
         if (t == 4) chk("glitch_busy_in_check", {31'd0, bus.busy}, 32'd1);
         if (t == 6) chk("glitch_busy_dropped", {31'd0, bus.busy}, 32'd0);
         if (bus.shift_strobe || bus.load_buffer) cnt++;
         bus.serial_in = (t >= 2);
      end
      chk("glitch_no_strobe_load", cnt, 0);

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].data, ^vecs[i].data, vecs[i].stop, vecs[i].rd_before,
                   vecs[i].rd_at_load, vecs[i].exp_load, vecs[i].exp_fe,
                   vecs[i].exp_dr, vecs[i].exp_ovr, 1'b0);
         repeat (2) @(negedge clk);
      end

      // Reset in the middle of a frame while the line is low.
      @(negedge clk);
      bus.serial_in = 1'b0;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         bus.serial_in = line_at((t + 1) / CPB, 8'hA5, ^8'hA5, 1'b1);
      end
      @(negedge clk);
      bus.serial_in = 1'b0;
      n_rst = 1'b0;
      #1;
      chk("mid_frame_reset_outputs", all_out(), 32'd0);
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.busy || bus.shift_strobe || bus.load_buffer) cnt++;
      end
      chk("no_activity_after_reset", cnt, 0);
      bus.serial_in = 1'b1;
      repeat (5) @(negedge clk);
      run_frame(8'hC3, ^8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef STP_RX_PARITY_EN
      repeat (2) @(negedge clk);
      run_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      repeat (2) @(negedge clk);
      run_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
